mux_select_arbiter: RTL and testbench
=====================================

MUX_SELECT_ARBITER -- requirements
Module: mux_select_arbiter

Interface
REQ-001 Parameter N, default 4, meaning number of requesters sharing the mux; legal values 2..8.
REQ-002 Parameter SW, default 2, meaning select width; it SHALL equal ceil(log2(N)).
REQ-003 Parameter MAX_HOLD, default 8, meaning the maximum number of consecutive cycles one owner may hold a grant; legal values 1..255.
REQ-004 Port clk  input  1  meaning the single rising-edge clock.
REQ-005 Port rst_n  input  1  meaning the reset; it is asynchronous and active-low.
REQ-006 Port req  input  N  meaning that requester i drives req[i] high to request the mux.
REQ-007 Port data_in  input  N  meaning the data bit from requester i.
REQ-008 Port grant  output  N  meaning the one-hot grant to the current owner; it is registered.
REQ-009 Port sel  output  SW  meaning the mux select, equal to the index of the current owner; it is registered.
REQ-010 Port valid  output  1  meaning that a grant is active this cycle; it is registered.
REQ-011 Port z  output  1  meaning the shared mux output.

Function
REQ-012 The block SHALL implement a two-state FSM, IDLE and OWN, with state register, owner index, last-owner pointer and hold counter.
REQ-013 In IDLE with req==0, the block SHALL stay in IDLE with grant=0 and valid=0.
REQ-014 In IDLE with any req bit high at a clock edge, the block SHALL enter OWN on that edge, with the following registered outputs:
  - grant one-hot to the winner;
  - sel equal to the winner index;
  - valid=1;
  - hold counter=0.
REQ-015 The winner SHALL be the first requester with req high, searching round-robin from last_owner+1 modulo N upward.
REQ-016 Grant latency SHALL be exactly one clock: req sampled at edge k gives grant visible after edge k.
REQ-017 In OWN, while req[sel]==1 and hold counter < MAX_HOLD-1, the block SHALL keep the grant and increment the hold counter by 1 each cycle.
REQ-018 On release, the block SHALL set last_owner to the releasing owner and apply one rule on the same edge, with no idle bubble. Release occurs when:
  - req[sel]==0 (voluntary), or
  - hold counter==MAX_HOLD-1 with req[sel] still high (forced).
  The rule on that edge is:
  - Other requests pending: grant the round-robin winner and stay in OWN.
  - No requests pending: go to IDLE with grant=0 and valid=0.
REQ-019 On forced release with no other requester pending, the block SHALL re-grant the same owner and reset the hold counter to 0.
REQ-020 z SHALL be combinational: z = data_in[sel] when valid==1, else 0.
REQ-021 grant SHALL never have more than one bit set, and SHALL equal (1<<sel) whenever valid==1.
REQ-022 Request bits at index >= N SHALL not exist, and the round-robin wrap SHALL be modulo N, not modulo 2^SW.
REQ-023 A requester lowering and raising req within the same owned cycle has no effect: req is sampled only at clock edges.

Reset
REQ-024 While rst_n==0, the block SHALL asynchronously force all of the following:
  - state=IDLE;
  - grant=0, sel=0, valid=0, and therefore z=0;
  - hold counter=0;
  - last_owner=N-1, so requester 0 has first priority after reset.
REQ-025 Reset asserted mid-grant SHALL drop grant and valid immediately, without waiting for a clock edge.
REQ-026 After rst_n deasserts, the first arbitration SHALL occur on the first clock edge at which any req is high.

Structure
REQ-027 The state encodings (IDLE=0, OWN=1) and the default parameter values SHALL live in a shared include file, mux_arb_defs.vh.
REQ-028 The round-robin search SHALL be a separate combinational sub-module, rr_pick, with the following ports:
  - inputs: req, the pointer, and an exclude-owner flag;
  - outputs: the winner index and a found flag.
REQ-029 The FSM, counter and pointer SHALL reside in mux_select_arbiter, which instantiates rr_pick once.

Verification
REQ-030 Reset then single request: reset, then req=4'b0100 -> after the next edge grant=4'b0100, sel=2, valid=1, and z follows data_in[2].
REQ-031 Simultaneous requests after reset: req=4'b1111 held with MAX_HOLD=8 -> owners 0,1,2,3,0 in turn, each held 8 cycles, with back-to-back handoff and valid continuously 1.
REQ-032 Voluntary release: owner 1 drops req after 3 cycles while req[3]=1 -> grant=4'b1000 on the release edge; when req drops to 0, the next edge gives valid=0 and z=0.
REQ-033 Forced release with sole requester: only req[2]=1, held 20 cycles, MAX_HOLD=8 -> grant stays 4'b0100 and the hold counter wraps at 7, 7, then 3.
REQ-034 Reset mid-grant: rst_n pulsed low while owner 3 holds -> grant=0 and valid=0 asynchronously; after release with req=4'b1001, requester 0 wins first.
REQ-035 Mux path: while owner 0 holds, toggle data_in[0] and data_in[1] -> z tracks only data_in[0], and grant stays one-hot throughout.

Source files
------------

// File: rtl/mux_select_arbiter_pkg.sv
// Shared types and defaults for the round-robin mux select arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mux_select_arbiter_pkg;

`include "mux_arb_defs.vh"

    localparam int N_DEF        = `MUX_ARB_N_DEF;
    localparam int SW_DEF       = `MUX_ARB_SW_DEF;
    localparam int MAX_HOLD_DEF = `MUX_ARB_MAX_HOLD_DEF;

    // Hold counter is sized for the largest legal MAX_HOLD (255).
    localparam int HOLD_W = 8;

    typedef enum logic {
        IDLE = `MUX_ARB_IDLE,
        OWN  = `MUX_ARB_OWN
    } state_t;

endpackage

// File: rtl/mux_arb_defs.vh
`ifndef MUX_ARB_DEFS_VH
`define MUX_ARB_DEFS_VH

// Shared defaults and state encodings for the mux select arbiter.
`define MUX_ARB_N_DEF        4
`define MUX_ARB_SW_DEF       2
`define MUX_ARB_MAX_HOLD_DEF 8

`define MUX_ARB_IDLE 1'b0
`define MUX_ARB_OWN  1'b1

`endif

// File: rtl/mux_select_arbiter_rr_pick.sv
// Round-robin search: first set req bit starting at ptr+1 (mod N) upward.
// Latency: purely combinational.
// Backpressure: none; found=0 when no eligible request exists.
//
// Ports:
//   req   - request vector
//   ptr   - search starts just after this index
//   excl  - when set, index ptr itself is never picked (search covers the other N-1)
//   win   - winning index (0 when found=0)
//   found - an eligible request was found
module rr_pick #(
    parameter int N  = 4,
    parameter int SW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    input  logic          excl,
    output logic [SW-1:0] win,
    output logic          found
);

    always_comb begin
        int idx;
        idx   = 0;
        win   = '0;
        found = 1'b0;
        // k==N lands back on ptr: it is the lowest-priority candidate and is
        // skipped entirely when the current owner must be excluded.
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx] && !(excl && (k == N))) begin
                found = 1'b1;
                win   = SW'(idx);
            end
        end
    end

endmodule

// File: rtl/mux_select_arbiter.sv
// Round-robin arbiter with bounded hold time driving a shared N:1 mux select.
// Latency: grant/sel/valid registered, one clock after req; z combinational from sel.
// Backpressure: owners lose the grant after MAX_HOLD cycles if others are waiting.
//
// Ports:
//   clk, rst_n - rising-edge clock, asynchronous active-low reset
//   req        - per-requester request bits
//   data_in    - per-requester data bits
//   grant      - one-hot grant to the current owner (registered)
//   sel        - index of the current owner (registered)
//   valid      - a grant is active (registered)
//   z          - data_in[sel] while valid, else 0
module mux_select_arbiter
    import mux_select_arbiter_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int SW       = SW_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  data_in,
    output logic [N-1:0]  grant,
    output logic [SW-1:0] sel,
    output logic          valid,
    output logic          z
);

    state_t              state_q, state_d;
    logic [SW-1:0]       sel_q, sel_d;
    logic [N-1:0]        grant_q, grant_d;
    logic                valid_q, valid_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [SW-1:0]       last_q, last_d;

    logic [SW-1:0]       pick_ptr;
    logic                pick_excl;
    logic [SW-1:0]       pick_win;
    logic                pick_found;
    logic                owner_req;
    logic                hold_room;

    // While owning, search past the current owner and never pick it, so a
    // miss means "nobody else is waiting". From idle, search past last_owner.
    assign pick_ptr  = (state_q == OWN) ? sel_q : last_q;
    assign pick_excl = (state_q == OWN);

    rr_pick #(
        .N  (N),
        .SW (SW)
    ) u_rr_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .excl  (pick_excl),
        .win   (pick_win),
        .found (pick_found)
    );

    assign owner_req = req[sel_q];
    assign hold_room = (hold_q < HOLD_W'(MAX_HOLD - 1));

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        valid_d = valid_q;
        hold_d  = hold_q;
        last_d  = last_q;

        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = OWN;
                    sel_d   = pick_win;
                    grant_d = N'(1) << pick_win;
                    valid_d = 1'b1;
                    hold_d  = '0;
                end else begin
                    grant_d = '0;
                    valid_d = 1'b0;
                end
            end

            OWN: begin
                if (owner_req && hold_room) begin
                    hold_d = hold_q + HOLD_W'(1);
                end else begin
                    // Release (voluntary or forced): hand off on this edge.
                    last_d = sel_q;
                    hold_d = '0;
                    if (pick_found) begin
                        sel_d   = pick_win;
                        grant_d = N'(1) << pick_win;
                    end else if (!owner_req) begin
                        state_d = IDLE;
                        grant_d = '0;
                        valid_d = 1'b0;
                    end
                    // else: forced release with nobody else waiting, so the
                    // same owner is re-granted with a fresh hold window.
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
                valid_d = 1'b0;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
            hold_q  <= '0;
            last_q  <= SW'(N - 1);
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
        end
    end

    assign grant = grant_q;
    assign sel   = sel_q;
    assign valid = valid_q;
    assign z     = valid_q ? data_in[sel_q] : 1'b0;

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Directed bench for mux_select_arbiter (N=4, SW=2, MAX_HOLD=8).
// Latency: checks one-clock grant latency and same-edge handoff.
// Backpressure: exercises forced release after MAX_HOLD cycles.
module tb_mux_select_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] data_in;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       valid;
    logic       z;

    int n_cmp;
    int n_fail;

    mux_select_arbiter #(
        .N        (4),
        .SW       (2),
        .MAX_HOLD (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .data_in (data_in),
        .grant   (grant),
        .sel     (sel),
        .valid   (valid),
        .z       (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        req     = 4'b1111;
        data_in = 4'b1111;
        step();
        step();
        n_cmp++; if (grant !== 4'b0000) begin $display("FAIL reset_grant got=%b exp=0000", grant); n_fail++; end
        n_cmp++; if (sel !== 2'd0) begin $display("FAIL reset_sel got=%0d exp=0", sel); n_fail++; end
        n_cmp++; if (valid !== 1'b0) begin $display("FAIL reset_valid got=%b exp=0", valid); n_fail++; end
        n_cmp++; if (z !== 1'b0) begin $display("FAIL reset_z got=%b exp=0", z); n_fail++; end
        n_cmp++; if (dut.hold_q !== 8'd0) begin $display("FAIL reset_hold got=%0d exp=0", dut.hold_q); n_fail++; end
        n_cmp++; if (dut.last_q !== 2'd3) begin $display("FAIL reset_last got=%0d exp=3", dut.last_q); n_fail++; end
        req = 4'b0000;
        rst_n = 1'b1;
        step();
        n_cmp++; if (valid !== 1'b0) begin $display("FAIL idle_no_req_valid got=%b exp=0", valid); n_fail++; end
        n_cmp++; if (grant !== 4'b0000) begin $display("FAIL idle_no_req_grant got=%b exp=0000", grant); n_fail++; end
    endtask

    task automatic test_single();
        req     = 4'b0100;
        data_in = 4'b0100;
        step();
        n_cmp++; if (grant !== 4'b0100) begin $display("FAIL single_grant got=%b exp=0100", grant); n_fail++; end
        n_cmp++; if (sel !== 2'd2) begin $display("FAIL single_sel got=%0d exp=2", sel); n_fail++; end
        n_cmp++; if (valid !== 1'b1) begin $display("FAIL single_valid got=%b exp=1", valid); n_fail++; end
        n_cmp++; if (z !== 1'b1) begin $display("FAIL single_z_hi got=%b exp=1", z); n_fail++; end
        data_in = 4'b1011;
        #1;
        n_cmp++; if (z !== 1'b0) begin $display("FAIL single_z_lo got=%b exp=0", z); n_fail++; end
        req = 4'b0000;
        step();
        n_cmp++; if (valid !== 1'b0) begin $display("FAIL single_rel_valid got=%b exp=0", valid); n_fail++; end
        n_cmp++; if (grant !== 4'b0000) begin $display("FAIL single_rel_grant got=%b exp=0000", grant); n_fail++; end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        do_reset();
        req     = 4'b1111;
        data_in = 4'b0000;
        for (int o = 0; o < 5; o++) begin
            for (int c = 0; c < 8; c++) begin
                step();
                exp_g = 4'b0001 << (o % 4);
                n_cmp++; if (grant !== exp_g) begin $display("FAIL rr_grant o=%0d c=%0d got=%b exp=%b", o, c, grant, exp_g); n_fail++; end
                n_cmp++; if (sel !== 2'(o % 4)) begin $display("FAIL rr_sel o=%0d c=%0d got=%0d exp=%0d", o, c, sel, o % 4); n_fail++; end
                n_cmp++; if (valid !== 1'b1) begin $display("FAIL rr_valid o=%0d c=%0d got=%b exp=1", o, c, valid); n_fail++; end
                n_cmp++; if (dut.hold_q !== 8'(c)) begin $display("FAIL rr_hold o=%0d c=%0d got=%0d exp=%0d", o, c, dut.hold_q, c); n_fail++; end
            end
        end
        req = 4'b0000;
        step();
        n_cmp++; if (valid !== 1'b0) begin $display("FAIL rr_end_valid got=%b exp=0", valid); n_fail++; end
    endtask

    task automatic test_voluntary();
        do_reset();
        req     = 4'b1010;
        data_in = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            step();
            n_cmp++; if (grant !== 4'b0010) begin $display("FAIL vol_own1 c=%0d got=%b exp=0010", c, grant); n_fail++; end
        end
        req = 4'b1000;
        step();
        n_cmp++; if (grant !== 4'b1000) begin $display("FAIL vol_handoff got=%b exp=1000", grant); n_fail++; end
        n_cmp++; if (sel !== 2'd3) begin $display("FAIL vol_sel got=%0d exp=3", sel); n_fail++; end
        n_cmp++; if (dut.hold_q !== 8'd0) begin $display("FAIL vol_hold got=%0d exp=0", dut.hold_q); n_fail++; end
        n_cmp++; if (valid !== 1'b1) begin $display("FAIL vol_valid got=%b exp=1", valid); n_fail++; end
        req = 4'b0000;
        step();
        n_cmp++; if (valid !== 1'b0) begin $display("FAIL vol_idle_valid got=%b exp=0", valid); n_fail++; end
        n_cmp++; if (z !== 1'b0) begin $display("FAIL vol_idle_z got=%b exp=0", z); n_fail++; end
        n_cmp++; if (grant !== 4'b0000) begin $display("FAIL vol_idle_grant got=%b exp=0000", grant); n_fail++; end
    endtask

    task automatic test_forced_sole();
        do_reset();
        req = 4'b0100;
        for (int c = 0; c < 20; c++) begin
            step();
            n_cmp++; if (grant !== 4'b0100) begin $display("FAIL forced_grant c=%0d got=%b exp=0100", c, grant); n_fail++; end
            n_cmp++; if (valid !== 1'b1) begin $display("FAIL forced_valid c=%0d got=%b exp=1", c, valid); n_fail++; end
            n_cmp++; if (dut.hold_q !== 8'(c % 8)) begin $display("FAIL forced_hold c=%0d got=%0d exp=%0d", c, dut.hold_q, c % 8); n_fail++; end
        end
        req = 4'b0000;
        step();
        n_cmp++; if (valid !== 1'b0) begin $display("FAIL forced_end_valid got=%b exp=0", valid); n_fail++; end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req     = 4'b1000;
        data_in = 4'b1000;
        step();
        step();
        n_cmp++; if (grant !== 4'b1000) begin $display("FAIL midrst_pre got=%b exp=1000", grant); n_fail++; end
        n_cmp++; if (z !== 1'b1) begin $display("FAIL midrst_pre_z got=%b exp=1", z); n_fail++; end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (grant !== 4'b0000) begin $display("FAIL midrst_grant got=%b exp=0000", grant); n_fail++; end
        n_cmp++; if (valid !== 1'b0) begin $display("FAIL midrst_valid got=%b exp=0", valid); n_fail++; end
        n_cmp++; if (z !== 1'b0) begin $display("FAIL midrst_z got=%b exp=0", z); n_fail++; end
        req = 4'b1001;
        #1;
        rst_n = 1'b1;
        step();
        n_cmp++; if (grant !== 4'b0001) begin $display("FAIL midrst_first got=%b exp=0001", grant); n_fail++; end
        n_cmp++; if (sel !== 2'd0) begin $display("FAIL midrst_sel got=%0d exp=0", sel); n_fail++; end
        req = 4'b0000;
        step();
    endtask

    task automatic test_mux_path();
        logic [1:0] pat [4];
        logic [3:0] d;
        pat[0] = 2'b01;
        pat[1] = 2'b10;
        pat[2] = 2'b11;
        pat[3] = 2'b00;
        do_reset();
        req     = 4'b0001;
        data_in = 4'b0000;
        step();
        for (int i = 0; i < 4; i++) begin
            d       = {2'b00, pat[i]};
            data_in = d;
            #1;
            n_cmp++; if (z !== d[0]) begin $display("FAIL mux_z i=%0d got=%b exp=%b", i, z, d[0]); n_fail++; end
            n_cmp++; if (grant !== 4'b0001) begin $display("FAIL mux_grant i=%0d got=%b exp=0001", i, grant); n_fail++; end
            step();
        end
        req = 4'b0000;
        step();
    endtask

    task automatic test_wrap_handoff();
        // Owner 3 releasing with only requester 0 waiting must wrap to 0.
        do_reset();
        req = 4'b1000;
        step();
        req = 4'b0001;
        step();
        n_cmp++; if (grant !== 4'b0001) begin $display("FAIL wrap_grant got=%b exp=0001", grant); n_fail++; end
        n_cmp++; if (valid !== 1'b1) begin $display("FAIL wrap_valid got=%b exp=1", valid); n_fail++; end
        req = 4'b0000;
        step();
    endtask

    initial begin
        n_cmp   = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        req     = 4'b0000;
        data_in = 4'b0000;
        test_reset();
        test_single();
        test_round_robin();
        test_voluntary();
        test_forced_sole();
        test_reset_mid_grant();
        test_mux_path();
        test_wrap_handoff();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
